// File: rtl/quad_detent_decoder.sv
// Quadrature encoder front end: synchronise, debounce, track Gray steps and
// emit one cw/ccw pulse per mechanical detent, plus illegal-transition debug.
module quad_detent_decoder #(
  parameter int unsigned FILT_CYCLES      = 1000,
  parameter int unsigned STEPS_PER_DETENT = 4,
  parameter int unsigned ERR_CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 a,
  input  logic                 b,
  output logic                 cw,
  output logic                 ccw,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned FCW   = $clog2(FILT_CYCLES + 1);
  localparam int unsigned ACC_W = $clog2(STEPS_PER_DETENT) + 2;

  localparam logic [FCW-1:0]          FILT_LAST = FCW'(FILT_CYCLES - 1);
  localparam logic [FCW-1:0]          FCNT_ONE  = FCW'(1);
  localparam logic signed [ACC_W-1:0] ACC_ONE   = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_POS   = ACC_W'(STEPS_PER_DETENT);
  localparam logic signed [ACC_W-1:0] ACC_NEG   = -ACC_POS;

  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_t;

  typedef enum logic [1:0] {
    MV_NONE,
    MV_CW,
    MV_CCW,
    MV_BAD
  } move_t;

  // Two-stage synchronizer; idle level of the pulled-up pins is 1.
  logic a_meta, b_meta, sa, sb;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_meta <= 1'b1;
      b_meta <= 1'b1;
      sa     <= 1'b1;
      sb     <= 1'b1;
    end else begin
      a_meta <= a;
      b_meta <= b;
      sa     <= a_meta;
      sb     <= b_meta;
    end
  end

  // Per-pin stability filter: index 1 is channel A, index 0 is channel B.
  logic [1:0]     s_pin;
  logic [1:0]     f_pin;
  logic [FCW-1:0] fcnt [2];
  logic           fa, fb;

  assign s_pin = {sa, sb};
  assign fa    = f_pin[1];
  assign fb    = f_pin[0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      f_pin <= '1;
      for (int unsigned i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (s_pin[i] == f_pin[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILT_LAST) begin
          f_pin[i] <= s_pin[i];
          fcnt[i]  <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FCNT_ONE;
        end
      end
    end
  end

  // Step tracker state: previous filtered phase.
  phase_t cur, prev_q;
  phase_t succ_cw, succ_ccw;
  move_t  move;

  logic signed [ACC_W-1:0] acc_q, acc_d, acc_step;
  logic                    cw_d, ccw_d, err_d;
  logic [ERR_CNT_W-1:0]    err_cnt_d;

  assign cur = phase_t'({fa, fb});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q  <= PH_11;
      acc_q   <= '0;
      cw      <= 1'b0;
      ccw     <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      prev_q  <= cur;
      acc_q   <= acc_d;
      cw      <= cw_d;
      ccw     <= ccw_d;
      err     <= err_d;
      err_cnt <= err_cnt_d;
    end
  end

  always_comb begin
    succ_cw  = PH_01;
    succ_ccw = PH_10;
    unique case (prev_q)
      PH_00: begin succ_cw = PH_01; succ_ccw = PH_10; end
      PH_01: begin succ_cw = PH_11; succ_ccw = PH_00; end
      PH_11: begin succ_cw = PH_10; succ_ccw = PH_01; end
      PH_10: begin succ_cw = PH_00; succ_ccw = PH_11; end
    endcase

    if (cur == prev_q)        move = MV_NONE;
    else if (cur == succ_cw)  move = MV_CW;
    else if (cur == succ_ccw) move = MV_CCW;
    else                      move = MV_BAD;
  end

  always_comb begin
    acc_d     = acc_q;
    acc_step  = acc_q;
    cw_d      = 1'b0;
    ccw_d     = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt;

    unique case (move)
      MV_NONE: ;
      MV_CW: begin
        acc_step = acc_q + ACC_ONE;
        if (acc_step == ACC_POS) begin
          cw_d  = 1'b1;
          acc_d = '0;
        end else begin
          acc_d = acc_step;
        end
      end
      MV_CCW: begin
        acc_step = acc_q - ACC_ONE;
        if (acc_step == ACC_NEG) begin
          ccw_d = 1'b1;
          acc_d = '0;
        end else begin
          acc_d = acc_step;
        end
      end
      MV_BAD: begin
        err_d = 1'b1;
        acc_d = '0;
      end
    endcase

    if (err_d && (err_cnt != '1)) err_cnt_d = err_cnt + ERR_CNT_W'(1);
  end

endmodule

// File: tb/tb_quad_detent_decoder.sv
// Directed bench for quad_detent_decoder (FILT_CYCLES=4, STEPS_PER_DETENT=4),
// with a second instance at ERR_CNT_W=2 sharing the pins for saturation.
module tb_quad_detent_decoder;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n;
  logic       a, b;
  logic       cw, ccw, err;
  logic [7:0] err_cnt;
  logic       cw2, ccw2, err2;
  logic [1:0] err_cnt2;

  int total = 0;
  int bad   = 0;
  int cw_n = 0, ccw_n = 0, err_n = 0, overlap_n = 0;
  logic any_q = 1'b0;
  int c0, cc0, e0;

  always #10 CLOCK_50 = ~CLOCK_50;

  quad_detent_decoder #(
    .FILT_CYCLES(4),
    .STEPS_PER_DETENT(4),
    .ERR_CNT_W(8)
  ) dut (
    .clk(CLOCK_50), .reset_n(reset_n), .a(a), .b(b),
    .cw(cw), .ccw(ccw), .err(err), .err_cnt(err_cnt)
  );

  quad_detent_decoder #(
    .FILT_CYCLES(4),
    .STEPS_PER_DETENT(4),
    .ERR_CNT_W(2)
  ) dut2 (
    .clk(CLOCK_50), .reset_n(reset_n), .a(a), .b(b),
    .cw(cw2), .ccw(ccw2), .err(err2), .err_cnt(err_cnt2)
  );

  // Pulse counters plus exclusivity / back-to-back pulse detection.
  always @(negedge CLOCK_50) begin
    if (cw === 1'b1)  cw_n++;
    if (ccw === 1'b1) ccw_n++;
    if (err === 1'b1) err_n++;
    if ((int'(cw) + int'(ccw) + int'(err)) > 1 || (any_q && (cw | ccw | err)))
      overlap_n++;
    any_q = cw | ccw | err;
  end

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    total++;
    if (got !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    {a, b} = ab;
    tick(n);
  endtask

  task automatic snap();
    c0  = cw_n;
    cc0 = ccw_n;
    e0  = err_n;
  endtask

  initial begin
    // 1: reset with pins low, then the 11->00 filtered jump is illegal
    reset_n = 1'b0;
    {a, b}  = 2'b00;
    tick(3);
    check("rst_cw", 32'(cw), 0);
    check("rst_ccw", 32'(ccw), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_err_cnt2", 32'(err_cnt2), 0);
    reset_n = 1'b1;
    tick(5);
    check("t1_fa_held", 32'(dut.fa), 1);
    check("t1_fb_held", 32'(dut.fb), 1);
    tick(1);
    check("t1_fa_fall", 32'(dut.fa), 0);
    check("t1_err_early", 32'(err), 0);
    tick(1);
    check("t1_err", 32'(err), 1);
    check("t1_err_cnt", 32'(err_cnt), 1);
    tick(1);
    check("t1_err_once", 32'(err), 0);
    tick(10);

    // 2: one full CW detent, pulse 7 clocks after final pin change
    snap();
    hold(2'b01, 10);
    hold(2'b11, 10);
    hold(2'b10, 10);
    {a, b} = 2'b00;
    tick(6);
    check("t2_cw_early", 32'(cw), 0);
    tick(1);
    check("t2_cw_pulse", 32'(cw), 1);
    tick(10);
    check("t2_cw_count", 32'(cw_n - c0), 1);
    check("t2_ccw_count", 32'(ccw_n - cc0), 0);
    check("t2_err_count", 32'(err_n - e0), 0);

    // 3: CCW detent, then a cancelled half-turn
    snap();
    hold(2'b10, 10);
    hold(2'b11, 10);
    hold(2'b01, 10);
    hold(2'b00, 20);
    check("t3_ccw_count", 32'(ccw_n - cc0), 1);
    check("t3_cw_none", 32'(cw_n - c0), 0);
    snap();
    hold(2'b01, 10);
    hold(2'b11, 10);
    hold(2'b01, 10);
    hold(2'b00, 20);
    check("t3_rev_cw", 32'(cw_n - c0), 0);
    check("t3_rev_ccw", 32'(ccw_n - cc0), 0);

    // 4: 3-clock glitch is rejected, 4-clock glitch gets through
    snap();
    hold(2'b10, 3);
    hold(2'b00, 12);
    check("t4_glitch3_fa", 32'(dut.fa), 0);
    a = 1'b1;
    tick(4);
    a = 1'b0;
    tick(2);
    check("t4_glitch4_fa", 32'(dut.fa), 1);
    tick(15);
    check("t4_fa_back", 32'(dut.fa), 0);
    check("t4_no_cw", 32'(cw_n - c0), 0);
    check("t4_no_ccw", 32'(ccw_n - cc0), 0);
    check("t4_no_err", 32'(err_n - e0), 0);

    // 5: illegal 01->10 clears the partial detent
    snap();
    hold(2'b01, 10);
    hold(2'b10, 12);
    check("t5_err_count", 32'(err_n - e0), 1);
    check("t5_err_cnt", 32'(err_cnt), 2);
    hold(2'b00, 10);
    hold(2'b01, 10);
    hold(2'b11, 10);
    check("t5_three_steps", 32'(cw_n - c0), 0);
    hold(2'b10, 10);
    check("t5_fourth_step", 32'(cw_n - c0), 1);

    // 6: counter saturation, then reset mid-detent
    {a, b}  = 2'b11;
    reset_n = 1'b0;
    tick(3);
    check("t6_rst_err_cnt", 32'(err_cnt), 0);
    reset_n = 1'b1;
    tick(10);
    snap();
    hold(2'b00, 12);
    hold(2'b11, 12);
    hold(2'b00, 12);
    hold(2'b11, 12);
    hold(2'b00, 12);
    check("t6_err_pulses", 32'(err_n - e0), 5);
    check("t6_err_cnt8", 32'(err_cnt), 5);
    check("t6_err_cnt2_sat", 32'(err_cnt2), 3);
    snap();
    hold(2'b01, 10);
    hold(2'b11, 10);
    hold(2'b10, 10);
    reset_n = 1'b0;
    tick(1);
    check("t6_mid_rst_cnt", 32'(err_cnt), 0);
    check("t6_mid_rst_cnt2", 32'(err_cnt2), 0);
    check("t6_mid_rst_cw", 32'(cw), 0);
    tick(2);
    reset_n = 1'b1;
    tick(12);
    hold(2'b00, 12);
    check("t6_partial_dropped", 32'(cw_n - c0), 0);
    check("t6_no_ccw", 32'(ccw_n - cc0), 0);

    check("pulse_exclusive", 32'(overlap_n), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
